// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared video-memory widths, fill state type and pixel address helper
package vga_pkg;
    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;
    localparam int ADDR_W  = 2 * COORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] row,
                                                     input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/raster_scan_counter.sv
// rtl/raster_scan_counter.sv - loadable row/column raster counter that stops on its last position
module raster_scan_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         hold_i,
    input  logic [W-1:0] rmin_i,
    input  logic [W-1:0] rmax_i,
    input  logic [W-1:0] cmin_i,
    input  logic [W-1:0] cmax_i,
    output logic [W-1:0] row_o,
    output logic [W-1:0] col_o,
    output logic         last_o
);
    logic [W-1:0] rmax_q, rmax_d;
    logic [W-1:0] cmin_q, cmin_d;
    logic [W-1:0] cmax_q, cmax_d;
    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == rmax_q) && (col_q == cmax_q);

    always_comb begin
        rmax_d = rmax_q;
        cmin_d = cmin_q;
        cmax_d = cmax_q;
        row_d  = row_q;
        col_d  = col_q;
        if (load_i) begin
            rmax_d = rmax_i;
            cmin_d = cmin_i;
            cmax_d = cmax_i;
            row_d  = rmin_i;
            col_d  = cmin_i;
        end else if (!hold_i && !last_o) begin
            // Stepping past the last position is suppressed so coordinates never wrap at 255.
            if (col_q < cmax_q) begin
                col_d = col_q + 1'b1;
            end else begin
                col_d = cmin_q;
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rmax_q <= '0;
            cmin_q <= '0;
            cmax_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            rmax_q <= rmax_d;
            cmin_q <= cmin_d;
            cmax_q <= cmax_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end
endmodule

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - video RAM write port owner arbitrating CPU pixel writes and rectangle fills
module vga_write_arbiter
    import vga_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iCpuWrite,
    input  logic [COORD_W-1:0] iCpuRow,
    input  logic [COORD_W-1:0] iCpuCol,
    input  logic [COLOR_W-1:0] iCpuColor,
    input  logic               iFillStart,
    input  logic               iFillAbort,
    input  logic [COORD_W-1:0] iFillRow0,
    input  logic [COORD_W-1:0] iFillRow1,
    input  logic [COORD_W-1:0] iFillCol0,
    input  logic [COORD_W-1:0] iFillCol1,
    input  logic [COLOR_W-1:0] iFillColor,
    output logic               oFillBusy,
    output logic               oFillDone,
    output logic               oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddress,
    output logic [COLOR_W-1:0] oWriteData
);
    fill_state_e        state_q, state_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;
    logic               done_q, done_d;

    logic [COORD_W-1:0] rmin, rmax, cmin, cmax;
    logic [COORD_W-1:0] scan_row, scan_col;
    logic               scan_last;
    logic               fill_load, fill_step;

    assign rmin = (iFillRow0 < iFillRow1) ? iFillRow0 : iFillRow1;
    assign rmax = (iFillRow0 < iFillRow1) ? iFillRow1 : iFillRow0;
    assign cmin = (iFillCol0 < iFillCol1) ? iFillCol0 : iFillCol1;
    assign cmax = (iFillCol0 < iFillCol1) ? iFillCol1 : iFillCol0;

    assign fill_load = (state_q == IDLE) && iFillStart;
    assign fill_step = (state_q == FILL) && !iFillAbort && !iCpuWrite;

    raster_scan_counter #(.W(COORD_W)) u_scan (
        .clk    (Clock),
        .rst    (Reset),
        .load_i (fill_load),
        .hold_i (!fill_step),
        .rmin_i (rmin),
        .rmax_i (rmax),
        .cmin_i (cmin),
        .cmax_i (cmax),
        .row_o  (scan_row),
        .col_o  (scan_col),
        .last_o (scan_last)
    );

    always_comb begin
        state_d = state_q;
        color_d = color_q;
        we_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        done_d  = 1'b0;
        // The CPU write is taken in every state, including alongside a start or an abort.
        if (iCpuWrite) begin
            we_d   = 1'b1;
            addr_d = pixel_addr(iCpuRow, iCpuCol);
            data_d = iCpuColor;
        end
        case (state_q)
            IDLE: begin
                if (iFillStart) begin
                    state_d = FILL;
                    color_d = iFillColor;
                end
            end
            FILL: begin
                if (iFillAbort) begin
                    state_d = IDLE;
                end else if (!iCpuWrite) begin
                    we_d   = 1'b1;
                    addr_d = pixel_addr(scan_row, scan_col);
                    data_d = color_q;
                    if (scan_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            color_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign oFillBusy     = (state_q == FILL);
    assign oFillDone     = done_q;
    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oWriteData    = data_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - vector table, corner sequences and randomized model comparison for vga_write_arbiter
module tb_vga_write_arbiter;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        iCpuWrite;
    logic [7:0]  iCpuRow, iCpuCol;
    logic [2:0]  iCpuColor;
    logic        iFillStart, iFillAbort;
    logic [7:0]  iFillRow0, iFillRow1, iFillCol0, iFillCol1;
    logic [2:0]  iFillColor;
    logic        oFillBusy, oFillDone, oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [2:0]  oWriteData;

    always #10 Clock = ~Clock;

    vga_write_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWrite(iCpuWrite), .iCpuRow(iCpuRow), .iCpuCol(iCpuCol), .iCpuColor(iCpuColor),
        .iFillStart(iFillStart), .iFillAbort(iFillAbort),
        .iFillRow0(iFillRow0), .iFillRow1(iFillRow1), .iFillCol0(iFillCol0), .iFillCol1(iFillCol1),
        .iFillColor(iFillColor),
        .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oWriteEnable(oWriteEnable),
        .oWriteAddress(oWriteAddress), .oWriteData(oWriteData)
    );

    typedef struct {
        logic       cpu;
        logic [7:0] crow, ccol;
        logic [2:0] ccolor;
        logic       start, abort;
        logic [7:0] r0, r1, c0, c1;
        logic [2:0] fcolor;
        logic       we;
        logic [15:0] addr;
        logic [2:0] data;
        logic       done, busy;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [15:0] mq[$];
    logic [2:0]  mcolor;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cpu, input logic [7:0] crow, input logic [7:0] ccol,
                         input logic [2:0] ccolor, input logic start, input logic abort,
                         input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] c0,
                         input logic [7:0] c1, input logic [2:0] fcolor);
        iCpuWrite = cpu; iCpuRow = crow; iCpuCol = ccol; iCpuColor = ccolor;
        iFillStart = start; iFillAbort = abort;
        iFillRow0 = r0; iFillRow1 = r1; iFillCol0 = c0; iFillCol1 = c1; iFillColor = fcolor;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [15:0] addr,
                             input logic [2:0] data, input logic done, input logic busy);
        chk({tag, ".we"}, oWriteEnable, we);
        chk({tag, ".done"}, oFillDone, done);
        chk({tag, ".busy"}, oFillBusy, busy);
        if (we) begin
            chk({tag, ".addr"}, oWriteAddress, addr);
            chk({tag, ".data"}, oWriteData, data);
        end
    endtask

    function automatic vec_t V(input logic cpu, input logic [7:0] crow, input logic [7:0] ccol,
                               input logic [2:0] ccolor, input logic start, input logic abort,
                               input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] c0,
                               input logic [7:0] c1, input logic [2:0] fcolor, input logic we,
                               input logic [15:0] addr, input logic [2:0] data,
                               input logic done, input logic busy);
        vec_t v;
        v.cpu = cpu; v.crow = crow; v.ccol = ccol; v.ccolor = ccolor;
        v.start = start; v.abort = abort; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
        v.fcolor = fcolor; v.we = we; v.addr = addr; v.data = data; v.done = done; v.busy = busy;
        return v;
    endfunction

    // Reference: a fill is the ordered list of every pixel of the rectangle, consumed one per free cycle.
    task automatic model_step(input logic cpu, input logic [7:0] crow, input logic [7:0] ccol,
                              input logic [2:0] ccolor, input logic start, input logic abort,
                              input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] c0,
                              input logic [7:0] c1, input logic [2:0] fcolor,
                              output logic we, output logic [15:0] addr, output logic [2:0] data,
                              output logic done, output logic busy);
        int rlo, rhi, clo, chi;
        we = 0; addr = 0; data = 0; done = 0;
        if (cpu) begin
            we = 1; addr = {crow, ccol}; data = ccolor;
        end
        if (mq.size() > 0) begin
            if (abort) begin
                mq.delete();
            end else if (!cpu) begin
                we = 1; addr = mq.pop_front(); data = mcolor;
                done = (mq.size() == 0);
            end
        end else if (start) begin
            rlo = (r0 < r1) ? r0 : r1; rhi = (r0 < r1) ? r1 : r0;
            clo = (c0 < c1) ? c0 : c1; chi = (c0 < c1) ? c1 : c0;
            mcolor = fcolor;
            for (int r = rlo; r <= rhi; r++)
                for (int c = clo; c <= chi; c++)
                    mq.push_back({r[7:0], c[7:0]});
        end
        busy = (mq.size() > 0);
    endtask

    function automatic logic [7:0] rand_coord();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(248, 255));
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [7:0] near(input logic [7:0] a);
        int k, v;
        k = $urandom_range(0, 4);
        v = ($urandom_range(0, 1) == 1) ? int'(a) + k : int'(a) - k;
        if (v > 255) v = 255;
        if (v < 0) v = 0;
        return v[7:0];
    endfunction

    initial begin
        vec_t vecs[27];
        int fill_writes, dones, late_writes;
        logic [15:0] last_addr;
        logic ewe, edone, ebusy;
        logic [15:0] eaddr;
        logic [2:0] edata;
        logic cpu, start, abort;
        logic [7:0] crow, ccol, r0, r1, c0, c1;
        logic [2:0] ccolor, fcolor;

        vecs[0]  = V(1, 8'h12, 8'h34, 5, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 5, 0, 0);
        vecs[1]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = V(0, 0, 0, 0, 1, 0, 3, 2, 12, 10, 2, 0, 0, 0, 0, 1);
        vecs[3]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h020A, 2, 0, 1);
        vecs[4]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h020B, 2, 0, 1);
        vecs[5]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h020C, 2, 0, 1);
        vecs[6]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h030A, 2, 0, 1);
        vecs[7]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h030B, 2, 0, 1);
        vecs[8]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h030C, 2, 1, 0);
        vecs[9]  = V(0, 0, 0, 0, 1, 0, 3, 2, 12, 10, 2, 0, 0, 0, 0, 1);
        vecs[10] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h020A, 2, 0, 1);
        vecs[11] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h020B, 2, 0, 1);
        vecs[12] = V(1, 8'hFF, 8'hFF, 7, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 7, 0, 1);
        vecs[13] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h020C, 2, 0, 1);
        vecs[14] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h030A, 2, 0, 1);
        vecs[15] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h030B, 2, 0, 1);
        vecs[16] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h030C, 2, 1, 0);
        vecs[17] = V(0, 0, 0, 0, 1, 0, 7, 7, 7, 7, 3, 0, 0, 0, 0, 1);
        vecs[18] = V(0, 0, 0, 0, 1, 0, 0, 9, 0, 9, 6, 1, 16'h0707, 3, 1, 0);
        vecs[19] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[20] = V(1, 1, 2, 4, 1, 0, 5, 5, 6, 6, 1, 1, 16'h0102, 4, 0, 1);
        vecs[21] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0506, 1, 1, 0);
        vecs[22] = V(1, 3, 3, 2, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0303, 2, 0, 0);
        vecs[23] = V(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5, 0, 0, 0, 0, 1);
        vecs[24] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 5, 0, 1);
        vecs[25] = V(1, 9, 9, 6, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0909, 6, 0, 0);
        vecs[26] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        Reset = 1'b1;
        idle_in();
        tick(); tick();
        check_out("reset", 0, 0, 0, 0, 0);
        chk("reset.addr", oWriteAddress, 16'h0000);
        chk("reset.data", oWriteData, 3'd0);
        Reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].cpu, vecs[i].crow, vecs[i].ccol, vecs[i].ccolor, vecs[i].start,
                  vecs[i].abort, vecs[i].r0, vecs[i].r1, vecs[i].c0, vecs[i].c1, vecs[i].fcolor);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                      vecs[i].done, vecs[i].busy);
        end

        // Full-screen fill aborted after 100 pixels, then an immediate restart.
        drive(0, 0, 0, 0, 1, 0, 0, 255, 255, 0, 4);
        tick();
        chk("full.start_busy", oFillBusy, 1'b1);
        idle_in();
        fill_writes = 0; dones = 0; last_addr = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (oWriteEnable) begin
                fill_writes++;
                last_addr = oWriteAddress;
            end
            if (oFillDone) dones++;
        end
        chk("full.writes", fill_writes, 100);
        chk("full.last_addr", last_addr, 16'h0063);
        chk("full.dones", dones, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        check_out("full.abort", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 2);
        tick();
        check_out("full.restart", 0, 0, 0, 0, 1);
        idle_in();
        tick();
        check_out("full.restart_px", 1, 16'h0101, 2, 1, 0);

        // Asynchronous reset in the middle of a 10x10 fill.
        drive(0, 0, 0, 0, 1, 0, 0, 9, 0, 9, 1);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) tick();
        chk("midrst.pre_we", oWriteEnable, 1'b1);
        #8;
        Reset = 1'b1;
        #1;
        check_out("midrst.async", 0, 0, 0, 0, 0);
        tick(); tick();
        Reset = 1'b0;
        late_writes = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oWriteEnable) late_writes++;
            if (oFillDone || oFillBusy) dones++;
        end
        chk("midrst.late_writes", late_writes, 0);
        chk("midrst.late_activity", dones, 0);

        // Randomized traffic against the reference model.
        mq.delete();
        for (int i = 0; i < 4000; i++) begin
            cpu    = ($urandom_range(0, 3) == 0);
            crow   = rand_coord();
            ccol   = rand_coord();
            ccolor = 3'($urandom_range(0, 7));
            start  = ($urandom_range(0, 5) == 0);
            abort  = ($urandom_range(0, 40) == 0);
            r0     = rand_coord();
            r1     = near(r0);
            c0     = rand_coord();
            c1     = near(c0);
            fcolor = 3'($urandom_range(0, 7));
            drive(cpu, crow, ccol, ccolor, start, abort, r0, r1, c0, c1, fcolor);
            model_step(cpu, crow, ccol, ccolor, start, abort, r0, r1, c0, c1, fcolor,
                       ewe, eaddr, edata, edone, ebusy);
            tick();
            check_out($sformatf("rand%0d", i), ewe, eaddr, edata, edone, ebusy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Sole owner of the video-memory write port (256x256 pixels, 3-bit colour, address = {row, col}).
- Arbitrates between two sources:
  - single-pixel CPU writes issued by the VGA instruction, which are never stalled;
  - a rectangle-fill engine that rasters a colour over an inclusive rectangle.
- The fill engine gives the CPU a fast clear/fill path without running a software loop.
- Outputs drive the video RAM write port directly; the VGA read side is untouched.

Parameters:
- COORD_W, 8, width of row and column coordinates.
- ADDR_W, 16, video RAM write address width; must equal 2*COORD_W.
- COLOR_W, 3, pixel colour width.

Ports:
- Clock  in  1  system clock (50 MHz); all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- iCpuWrite  in  1  single-cycle CPU pixel-write request.
- iCpuRow  in  COORD_W  CPU pixel row.
- iCpuCol  in  COORD_W  CPU pixel column.
- iCpuColor  in  COLOR_W  CPU pixel colour.
- iFillStart  in  1  starts a fill; honoured only in IDLE.
- iFillAbort  in  1  stops an active fill.
- iFillRow0, iFillRow1  in  COORD_W  rectangle row bounds, any order.
- iFillCol0, iFillCol1  in  COORD_W  rectangle column bounds, any order.
- iFillColor  in  COLOR_W  fill colour.
- oFillBusy  out  1  high while state is FILL.
- oFillDone  out  1  one-cycle pulse when the last fill pixel is presented.
- oWriteEnable  out  1  RAM write enable (registered).
- oWriteAddress  out  ADDR_W  RAM write address {row, col} (registered).
- oWriteData  out  COLOR_W  RAM write data (registered).

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; counters and latched bounds 0. Reset during a fill abandons it, with no oFillDone pulse.
- All outputs are registered. Write latency is exactly 1 cycle from the sampling edge to the write appearing on the port.
- CPU path:
  - iCpuWrite sampled high at edge N: at edge N the port registers load WE=1, address {iCpuRow, iCpuCol}, data iCpuColor. The write is visible during cycle N+1.
  - The CPU always wins. No CPU request is ever dropped or delayed.
- IDLE state:
  - iFillStart=1 latches rmin=min(Row0,Row1), rmax=max(Row0,Row1), cmin=min(Col0,Col1), cmax=max(Col0,Col1) and the colour.
  - Sets row=rmin, col=cmin; goes to FILL.
  - No fill pixel is emitted on the start edge.
- FILL state, each edge:
  - iFillAbort=1: go to IDLE; no pixel emitted, no oFillDone. Abort has priority over both CPU and fill stepping, but a simultaneous CPU write is still performed.
  - Else if iCpuWrite=1: emit the CPU write; fill position holds.
  - Else: emit fill pixel {row, col}, then advance.
    - col<cmax: col+1.
    - col==cmax and row<rmax: col=cmin, row+1.
    - col==cmax and row==rmax: last pixel. Go to IDLE and register oFillDone=1, so the pulse coincides with the last pixel write.
- iFillStart outside IDLE is ignored. The bound and colour inputs are ignored outside the start edge.
- iFillStart on the same edge as iCpuWrite in IDLE: both are accepted. The CPU write is emitted; the fill's first pixel follows on the next edge.
- Degenerate rectangle (rmin==rmax, cmin==cmax): exactly one fill pixel, with oFillDone on that pixel.
- Duration: an uncontested fill of W*H pixels has oFillBusy high for exactly W*H cycles. Each CPU write during the fill adds one cycle.
- Overlap: a CPU write to a pixel not yet filled is later overwritten by the fill (last writer wins). Software must wait for oFillBusy=0 if ordering matters.
- No wrap-around at coordinate 255: bounds are normalised, and counters never exceed their max.

Decomposition:
- Shared package vga_pkg:
  - COORD_W, COLOR_W, ADDR_W constants.
  - state typedef {IDLE, FILL}.
  - pixel_addr(row, col) concatenation function, reused by the VGA controller.
- Natural sub-module: raster_scan_counter.
  - Loadable 2-D counter with min/max bounds and a hold input.
  - Outputs row, col, last.

Test Plan:
- Reset asserted mid-fill of (0,0)-(9,9) -> oFillBusy=0, oWriteEnable=0 in the same cycle as reset (asynchronous); no oFillDone; no further writes after release.
- iCpuWrite, row 0x12, col 0x34, colour 5, in IDLE -> exactly one cycle with WE=1, addr 0x1234, data 5, one cycle after the sampling edge.
- Fill rows 3..2 (reversed), cols 10..12, colour 2 -> 6 writes in the order 0x020A, 0x020B, 0x020C, 0x030A, 0x030B, 0x030C; oFillDone coincides with 0x030C; oFillBusy high for 6 cycles.
- Same fill with iCpuWrite (0xFFFF, colour 7) on the 3rd fill cycle -> the CPU write appears in that slot, the fill resumes at 0x020C, and 7 busy cycles total.
- Fill 0..255 x 0..255 with abort after 100 pixels -> exactly 100 fill writes, ending at address 0x0063; then IDLE with no oFillDone; a new iFillStart is accepted on the next edge.
- Single-pixel fill (7,7) with iFillStart repeated while busy -> one write at 0x0707 with oFillDone; the repeated start is ignored.
